// File: rtl/roulette_wheel_if.sv
// Handshake between the roulette wheel (producer) and the game FSM / display (consumer).
// The wheel is the slave side; the game drives spin_req/result_ack.
interface roulette_wheel_if;
  logic       spin_req;
  logic       result_ack;
  logic [4:0] randnum;
  logic       result_valid;
  logic       busy;
  logic [4:0] wheel_pos;
  logic       wheel_step;

  modport master (
    output spin_req, result_ack,
    input  randnum, result_valid, busy, wheel_pos, wheel_step
  );

  modport slave (
    input  spin_req, result_ack,
    output randnum, result_valid, busy, wheel_pos, wheel_step
  );
endinterface

// File: rtl/roulette_wheel.sv
// Decelerating roulette wheel: spins on a spin_req rising edge, lands on an LFSR-chosen
// number after at least MIN_STEPS steps, and holds it until the game acknowledges.
module roulette_wheel #(
  parameter logic [4:0] LFSR_SEED = 5'b00001,
  parameter int         RANGE_MAX = 31,
  parameter logic [7:0] BASE_DIV  = 8'd4,
  parameter logic [7:0] DECEL     = 8'd2,
  parameter logic [5:0] MIN_STEPS = 6'd32
) (
  input  logic               Clock,
  input  logic               reset_n,
  roulette_wheel_if.slave    bus
);

  localparam logic [4:0] RMAX = 5'(RANGE_MAX);

  typedef enum logic [1:0] {IDLE, SPIN, DONE} state_e;

  state_e     state_q;
  logic [4:0] lfsr_q, lfsr_d;
  logic       spin_prev_q;
  logic [4:0] target_q;
  logic [7:0] intv_q, tick_q;
  logic [5:0] cnt_q;
  logic [4:0] pos_q, randnum_q;
  logic       valid_q, busy_q, step_q;

  logic [4:0] tgt, pos_nxt;
  logic [5:0] cnt_nxt;
  logic [8:0] intv_sum;
  logic [7:0] intv_nxt;
  logic       rise, start, land;

  always_comb begin
    lfsr_d   = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    tgt      = (lfsr_q > RMAX) ? lfsr_q - RMAX : lfsr_q;
    rise     = bus.spin_req & ~spin_prev_q;
    // A rise in DONE restarts the wheel unless the game acks in the same cycle.
    start    = rise & ((state_q == IDLE) | ((state_q == DONE) & ~bus.result_ack));
    pos_nxt  = (pos_q == RMAX) ? 5'd1 : pos_q + 5'd1;
    cnt_nxt  = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
    intv_sum = {1'b0, intv_q} + {1'b0, DECEL};
    intv_nxt = intv_sum[8] ? 8'hFF : intv_sum[7:0];
    land     = (cnt_nxt >= MIN_STEPS) && (pos_nxt == target_q);
  end

  always_ff @(posedge Clock) begin
    // Tracks the level through reset too, so a button held across reset is not a new press.
    spin_prev_q <= bus.spin_req;
    if (!reset_n) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      target_q  <= 5'd0;
      intv_q    <= 8'd0;
      tick_q    <= 8'd0;
      cnt_q     <= 6'd0;
      pos_q     <= 5'd1;
      randnum_q <= 5'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      step_q <= 1'b0;
      if (start) begin
        state_q  <= SPIN;
        target_q <= tgt;
        intv_q   <= BASE_DIV;
        tick_q   <= BASE_DIV - 8'd1;
        cnt_q    <= 6'd0;
        busy_q   <= 1'b1;
        valid_q  <= 1'b0;
      end else begin
        case (state_q)
          SPIN: begin
            if (tick_q == 8'd0) begin
              pos_q  <= pos_nxt;
              step_q <= 1'b1;
              cnt_q  <= cnt_nxt;
              intv_q <= intv_nxt;
              tick_q <= intv_nxt - 8'd1;
              if (land) begin
                state_q   <= DONE;
                randnum_q <= target_q;
                valid_q   <= 1'b1;
                busy_q    <= 1'b0;
              end
            end else begin
              tick_q <= tick_q - 8'd1;
            end
          end
          DONE: begin
            if (bus.result_ack) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.randnum      = randnum_q;
  assign bus.result_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.wheel_pos    = pos_q;
  assign bus.wheel_step   = step_q;

endmodule
